// File: rtl/scroll_coord_gen.sv
// scroll_coord_gen: 640x480@60 raster timing plus scrolled cell coordinates
// for a sine-wave background layer.
//
// Ports
//   clk          pixel clock; all state changes on the rising edge
//   rst          asynchronous active-high reset
//   run          1 = scroll and frame counter advance at frame end
//   speed[1:0]   scroll step per frame in pixels
//   auto_dn      1 = automatic day/night toggling every DN_FRAMES frames
//   hsync/vsync  active-low syncs
//   active       inside the visible area
//   x[5:0]       scrolled horizontal cell ((hpos+scroll) mod 512) >> 3
//   y[4:0]       sine row ((vpos-V_OFS) >> 4), 31 outside the 352-line band
//   daynight     background select
//   frame_start  one-cycle pulse for pixel (0,0)
//
// Every output is registered and reflects the raster position one clock
// earlier. The timing geometry is parameterized; the defaults are the
// standard 800x525 raster.
module scroll_coord_gen #(
  parameter int DN_FRAMES = 256,
  parameter int V_OFS     = 64,
  parameter int H_VIS     = 640,
  parameter int H_SS      = 656,
  parameter int H_SE      = 752,
  parameter int H_TOT     = 800,
  parameter int V_VIS     = 480,
  parameter int V_SS      = 490,
  parameter int V_SE      = 492,
  parameter int V_TOT     = 525
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [1:0] speed,
  input  logic       auto_dn,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [5:0] x,
  output logic [4:0] y,
  output logic       daynight,
  output logic       frame_start
);

  localparam logic [9:0] HV  = 10'(H_VIS);
  localparam logic [9:0] HSS = 10'(H_SS);
  localparam logic [9:0] HSE = 10'(H_SE);
  localparam logic [9:0] HL  = 10'(H_TOT - 1);
  localparam logic [9:0] VV  = 10'(V_VIS);
  localparam logic [9:0] VSS = 10'(V_SS);
  localparam logic [9:0] VSE = 10'(V_SE);
  localparam logic [9:0] VL  = 10'(V_TOT - 1);
  localparam logic [9:0] VO  = 10'(V_OFS);
  localparam logic [9:0] VOE = 10'(V_OFS + 352);
  localparam logic [9:0] DNL = 10'(DN_FRAMES - 1);

  logic [9:0] hpos, vpos;
  logic [8:0] scroll;
  logic [9:0] frame_cnt;

  logic h_last, v_last, frame_end;
  logic act_c, band_c;
  logic [5:0] x_c;
  logic [4:0] y_c;

  assign h_last    = (hpos == HL);
  assign v_last    = (vpos == VL);
  // Last pixel of the last visible line: scroll and frame counter step here,
  // so the new values take effect with the next frame's first visible pixel.
  assign frame_end = h_last && (vpos == VV - 10'd1);

  assign act_c  = (hpos < HV) && (vpos < VV);
  assign band_c = (vpos >= VO) && (vpos < VOE);
  // 9-bit sum wraps mod 512 before the cell index is taken.
  assign x_c    = act_c ? 6'((hpos[8:0] + scroll) >> 3) : 6'd0;
  assign y_c    = (act_c && band_c) ? 5'((vpos - VO) >> 4) : 5'd31;

  // Raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
    end else if (h_last) begin
      hpos <= '0;
      vpos <= v_last ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos <= hpos + 10'd1;
    end
  end

  // Per-frame state: scroll offset, day/night frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll    <= '0;
      frame_cnt <= '0;
      daynight  <= 1'b0;
    end else if (frame_end && run) begin
      scroll <= scroll + {7'd0, speed};
      if (auto_dn) begin
        if (frame_cnt == DNL) begin
          frame_cnt <= '0;
          daynight  <= ~daynight;
        end else begin
          frame_cnt <= frame_cnt + 10'd1;
        end
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      x           <= '0;
      y           <= 5'd31;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !((hpos >= HSS) && (hpos < HSE));
      vsync       <= !((vpos >= VSS) && (vpos < VSE));
      active      <= act_c;
      x           <= x_c;
      y           <= y_c;
      frame_start <= (hpos == 10'd0) && (vpos == 10'd0);
    end
  end

endmodule

// File: tb/tb_scroll_coord_gen.sv
`timescale 1ns/1ps
// Directed bench for scroll_coord_gen. Three instances share the inputs:
//   a: default 800x525 raster (line-level x / hsync checks)
//   b: narrow 24-clock lines, full 525-line frame (y band, vsync, frame_start)
//   c: 12x8 micro raster, DN_FRAMES=4, V_OFS=0 (multi-frame scroll/day-night)
// cyc counts rising edges since reset release, so raster pixel p of instance
// with frame length F in frame f is visible after edge f*F+p+1.
module tb_scroll_coord_gen;

  logic clk = 1'b0;
  logic rst, run, auto_dn;
  logic [1:0] speed;

  logic hs_a, vs_a, act_a, dn_a, fs_a;
  logic hs_b, vs_b, act_b, dn_b, fs_b;
  logic hs_c, vs_c, act_c, dn_c, fs_c;
  logic [5:0] x_a, x_b, x_c;
  logic [4:0] y_a, y_b, y_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #20 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  scroll_coord_gen dut_a (
    .clk(clk), .rst(rst), .run(run), .speed(speed), .auto_dn(auto_dn),
    .hsync(hs_a), .vsync(vs_a), .active(act_a), .x(x_a), .y(y_a),
    .daynight(dn_a), .frame_start(fs_a));

  scroll_coord_gen #(.H_VIS(16), .H_SS(18), .H_SE(22), .H_TOT(24)) dut_b (
    .clk(clk), .rst(rst), .run(run), .speed(speed), .auto_dn(auto_dn),
    .hsync(hs_b), .vsync(vs_b), .active(act_b), .x(x_b), .y(y_b),
    .daynight(dn_b), .frame_start(fs_b));

  scroll_coord_gen #(.DN_FRAMES(4), .V_OFS(0),
    .H_VIS(8), .H_SS(9), .H_SE(10), .H_TOT(12),
    .V_VIS(4), .V_SS(5), .V_SE(6), .V_TOT(8)) dut_c (
    .clk(clk), .rst(rst), .run(run), .speed(speed), .auto_dn(auto_dn),
    .hsync(hs_c), .vsync(vs_c), .active(act_c), .x(x_c), .y(y_c),
    .daynight(dn_c), .frame_start(fs_c));

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic at(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // frame f, pixel p of dut_c (96-clock frames)
  function automatic int pc(input int f, input int p);
    return f * 96 + p + 1;
  endfunction

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; speed = 2'd0; auto_dn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (hs_a !== 1'b1)  begin errors++; $display("FAIL rst_hsync got %b want 1", hs_a); end
    checks++; if (vs_a !== 1'b1)  begin errors++; $display("FAIL rst_vsync got %b want 1", vs_a); end
    checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL rst_active got %b want 0", act_a); end
    checks++; if (x_a !== 6'd0)   begin errors++; $display("FAIL rst_x got %0d want 0", x_a); end
    checks++; if (y_a !== 5'd31)  begin errors++; $display("FAIL rst_y got %0d want 31", y_a); end
    checks++; if (fs_a !== 1'b0)  begin errors++; $display("FAIL rst_fs got %b want 0", fs_a); end
    checks++; if (dn_a !== 1'b0)  begin errors++; $display("FAIL rst_dn got %b want 0", dn_a); end
    rst = 1'b0;
    at(1);
    checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL rel_active got %b want 1", act_a); end
    checks++; if (fs_a !== 1'b1)  begin errors++; $display("FAIL rel_fs got %b want 1", fs_a); end
    checks++; if (x_a !== 6'd0)   begin errors++; $display("FAIL rel_x got %0d want 0", x_a); end
    checks++; if (y_a !== 5'd31)  begin errors++; $display("FAIL rel_y got %0d want 31", y_a); end
    checks++; if (hs_a !== 1'b1)  begin errors++; $display("FAIL rel_hsync got %b want 1", hs_a); end
  endtask

  // Line 0 of the default raster, scroll = 0.
  task automatic test_x_line;
    int hl;
    hl = 0;
    for (int p = 0; p < 800; p++) begin
      at(p + 1);
      if (!hs_a) hl++;
      case (p)
        1:   begin checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL fs_p1 got %b want 0", fs_a); end end
        8:   begin checks++; if (x_a !== 6'd1)  begin errors++; $display("FAIL x_p8 got %0d want 1", x_a); end end
        504: begin checks++; if (x_a !== 6'd63) begin errors++; $display("FAIL x_p504 got %0d want 63", x_a); end end
        511: begin checks++; if (x_a !== 6'd63) begin errors++; $display("FAIL x_p511 got %0d want 63", x_a); end end
        512: begin checks++; if (x_a !== 6'd0)  begin errors++; $display("FAIL x_p512 got %0d want 0", x_a); end end
        639: begin
          checks++; if (x_a !== 6'd15)  begin errors++; $display("FAIL x_p639 got %0d want 15", x_a); end
          checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL act_p639 got %b want 1", act_a); end
        end
        640: begin
          checks++; if (x_a !== 6'd0)   begin errors++; $display("FAIL x_p640 got %0d want 0", x_a); end
          checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL act_p640 got %b want 0", act_a); end
        end
        655: begin checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL hs_p655 got %b want 1", hs_a); end end
        656: begin checks++; if (hs_a !== 1'b0) begin errors++; $display("FAIL hs_p656 got %b want 0", hs_a); end end
        752: begin checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL hs_p752 got %b want 1", hs_a); end end
        default: ;
      endcase
    end
    checks++; if (hl != 96) begin errors++; $display("FAIL hsync_low_count got %0d want 96", hl); end
  endtask

  // Reset pulse mid-frame: dut_a at (300,6), dut_b at (12,212).
  task automatic test_async_reset;
    do_reset;
    at(5101);
    checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL pre_act_a got %b want 1", act_a); end
    checks++; if (x_a !== 6'd37)  begin errors++; $display("FAIL pre_x_a got %0d want 37", x_a); end
    checks++; if (y_b !== 5'd9)   begin errors++; $display("FAIL pre_y_b got %0d want 9", y_b); end
    #1 rst = 1'b1;
    #1;
    checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL ar_act_a got %b want 0", act_a); end
    checks++; if (x_a !== 6'd0)   begin errors++; $display("FAIL ar_x_a got %0d want 0", x_a); end
    checks++; if (y_b !== 5'd31)  begin errors++; $display("FAIL ar_y_b got %0d want 31", y_b); end
    checks++; if (hs_a !== 1'b1)  begin errors++; $display("FAIL ar_hs_a got %b want 1", hs_a); end
    @(negedge clk);
    rst = 1'b0;
    at(1);
    checks++; if (fs_a !== 1'b1)  begin errors++; $display("FAIL ar_fs_a got %b want 1", fs_a); end
    checks++; if (fs_b !== 1'b1)  begin errors++; $display("FAIL ar_fs_b got %b want 1", fs_b); end
    checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL ar_rel_act got %b want 1", act_a); end
    at(2);
    checks++; if (fs_a !== 1'b0)  begin errors++; $display("FAIL ar_fs_next got %b want 0", fs_a); end
  endtask

  // One full frame of dut_b: y band, vsync width, frame_start count.
  task automatic test_vsweep;
    int hl, vl, fsn, hp, vp;
    hl = 0; vl = 0; fsn = 0;
    do_reset;
    for (int p = 0; p < 12600; p++) begin
      at(p + 1);
      hp = p % 24; vp = p / 24;
      if (!hs_b) hl++;
      if (!vs_b) vl++;
      if (fs_b) fsn++;
      if (hp == 0) begin
        case (vp)
          63:  begin checks++; if (y_b !== 5'd31) begin errors++; $display("FAIL y_v63 got %0d want 31", y_b); end end
          64:  begin checks++; if (y_b !== 5'd0)  begin errors++; $display("FAIL y_v64 got %0d want 0", y_b); end end
          100: begin checks++; if (y_b !== 5'd2)  begin errors++; $display("FAIL y_v100 got %0d want 2", y_b); end end
          400: begin checks++; if (y_b !== 5'd21) begin errors++; $display("FAIL y_v400 got %0d want 21", y_b); end end
          415: begin checks++; if (y_b !== 5'd21) begin errors++; $display("FAIL y_v415 got %0d want 21", y_b); end end
          416: begin checks++; if (y_b !== 5'd31) begin errors++; $display("FAIL y_v416 got %0d want 31", y_b); end end
          480: begin
            checks++; if (y_b !== 5'd31)  begin errors++; $display("FAIL y_v480 got %0d want 31", y_b); end
            checks++; if (act_b !== 1'b0) begin errors++; $display("FAIL act_v480 got %b want 0", act_b); end
          end
          default: ;
        endcase
      end
      if (hp == 16 && vp == 100) begin
        checks++; if (y_b !== 5'd31) begin errors++; $display("FAIL y_blank_h got %0d want 31", y_b); end
      end
    end
    checks++; if (hl != 2100) begin errors++; $display("FAIL hsync_frame_low got %0d want 2100", hl); end
    checks++; if (vl != 48)   begin errors++; $display("FAIL vsync_low got %0d want 48", vl); end
    checks++; if (fsn != 1)   begin errors++; $display("FAIL fs_per_frame got %0d want 1", fsn); end
    at(12601);
    checks++; if (fs_b !== 1'b1) begin errors++; $display("FAIL fs_next_frame got %b want 1", fs_b); end
  endtask

  task automatic test_scroll;
    run = 1'b1; speed = 2'd3; auto_dn = 1'b0;
    do_reset;
    at(pc(0, 7));   checks++; if (x_c !== 6'd0) begin errors++; $display("FAIL sc_f0p7 got %0d want 0", x_c); end
    at(pc(1, 7));   checks++; if (x_c !== 6'd1) begin errors++; $display("FAIL sc_f1p7 got %0d want 1", x_c); end
    at(pc(4, 0));   checks++; if (x_c !== 6'd1) begin errors++; $display("FAIL sc_f4p0 got %0d want 1", x_c); end
                    checks++; if (y_c !== 5'd0) begin errors++; $display("FAIL sc_f4_y got %0d want 0", y_c); end
    at(pc(4, 4));   checks++; if (x_c !== 6'd2) begin errors++; $display("FAIL sc_f4p4 got %0d want 2", x_c); end
    at(pc(171, 0)); checks++; if (x_c !== 6'd0) begin errors++; $display("FAIL sc_f171p0 got %0d want 0", x_c); end
    at(pc(171, 2)); run = 1'b0; speed = 2'd2;
    at(pc(171, 7)); checks++; if (x_c !== 6'd1) begin errors++; $display("FAIL sc_f171p7 got %0d want 1", x_c); end
    at(pc(172, 3)); checks++; if (x_c !== 6'd0) begin errors++; $display("FAIL hold_f172p3 got %0d want 0", x_c); end
    run = 1'b1;
    at(pc(172, 7)); checks++; if (x_c !== 6'd1) begin errors++; $display("FAIL hold_f172p7 got %0d want 1", x_c); end
    at(pc(173, 4)); checks++; if (x_c !== 6'd0) begin errors++; $display("FAIL sc_f173p4 got %0d want 0", x_c); end
    at(pc(173, 5)); checks++; if (x_c !== 6'd1) begin errors++; $display("FAIL sc_f173p5 got %0d want 1", x_c); end
    at(pc(173, 6)); speed = 2'd1;
    at(pc(173, 7)); checks++; if (x_c !== 6'd1) begin errors++; $display("FAIL mid_f173p7 got %0d want 1", x_c); end
    at(pc(174, 3)); checks++; if (x_c !== 6'd0) begin errors++; $display("FAIL sc_f174p3 got %0d want 0", x_c); end
    at(pc(174, 4)); checks++; if (x_c !== 6'd1) begin errors++; $display("FAIL sc_f174p4 got %0d want 1", x_c); end
  endtask

  task automatic test_daynight;
    run = 1'b1; speed = 2'd0; auto_dn = 1'b1;
    do_reset;
    at(pc(0, 0));  checks++; if (dn_c !== 1'b0) begin errors++; $display("FAIL dn_f0 got %b want 0", dn_c); end
    at(pc(3, 0));  checks++; if (dn_c !== 1'b0) begin errors++; $display("FAIL dn_f3 got %b want 0", dn_c); end
    at(pc(4, 0));  checks++; if (dn_c !== 1'b1) begin errors++; $display("FAIL dn_f4 got %b want 1", dn_c); end
    at(pc(7, 0));  checks++; if (dn_c !== 1'b1) begin errors++; $display("FAIL dn_f7 got %b want 1", dn_c); end
    at(pc(8, 0));  checks++; if (dn_c !== 1'b0) begin errors++; $display("FAIL dn_f8 got %b want 0", dn_c); end
    at(pc(12, 0)); checks++; if (dn_c !== 1'b1) begin errors++; $display("FAIL dn_f12 got %b want 1", dn_c); end
    at(pc(12, 1)); auto_dn = 1'b0;
    at(pc(15, 1)); auto_dn = 1'b1;
                   checks++; if (dn_c !== 1'b1) begin errors++; $display("FAIL dn_f15 got %b want 1", dn_c); end
    at(pc(18, 0)); checks++; if (dn_c !== 1'b1) begin errors++; $display("FAIL dn_f18 got %b want 1", dn_c); end
    at(pc(19, 0)); checks++; if (dn_c !== 1'b0) begin errors++; $display("FAIL dn_f19 got %b want 0", dn_c); end
    at(pc(23, 0)); checks++; if (dn_c !== 1'b1) begin errors++; $display("FAIL dn_f23 got %b want 1", dn_c); end
    #1 rst = 1'b1;
    #1;
    checks++; if (dn_c !== 1'b0) begin errors++; $display("FAIL dn_async_rst got %b want 0", dn_c); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_x_line;
    test_async_reset;
    test_vsweep;
    test_scroll;
    test_daynight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
